// File: rtl/mux_2x1_rr.sv
// Two-lane round-robin combiner: each lane is buffered in its own FIFO and the
// lanes are merged onto one registered output stream, one word per clock.
module mux_2x1_rr #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full0,
  output logic             full1,
  output logic [1:0]       overflow
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] w_din  [2];
  logic [WIDTH-1:0] w_head [2];
  logic [1:0]       w_vin;
  logic [1:0]       w_nonempty;
  logic [1:0]       w_full;
  logic [1:0]       w_pop;
  logic [1:0]       w_push;
  logic [1:0]       w_drop;
  logic             w_grant_valid;
  logic             w_grant_lane;

  logic [WIDTH-1:0] r_data_out;
  logic             r_valid_out;
  logic             r_last_grant;
  logic [1:0]       r_overflow;

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_vin    = {valid_in1, valid_in0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wptr;
      logic [AW-1:0]    r_rptr;
      logic [CNTW-1:0]  r_count;

      assign w_nonempty[gi] = (r_count != '0);
      assign w_full[gi]     = (r_count == FULL_CNT);
      assign w_head[gi]     = r_mem[r_rptr];
      assign w_pop[gi]      = w_grant_valid && (w_grant_lane == 1'(gi));
      // A full lane still accepts a word when its head leaves on the same edge.
      assign w_push[gi]     = w_vin[gi] && (!w_full[gi] || w_pop[gi]);
      assign w_drop[gi]     = w_vin[gi] && !w_push[gi];

      always_ff @(posedge clk) begin
        if (w_push[gi] && !reset) begin
          r_mem[r_wptr] <= w_din[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[gi]) r_wptr <= r_wptr + AW'(1);
          if (w_pop[gi])  r_rptr <= r_rptr + AW'(1);
          if (w_push[gi] && !w_pop[gi]) begin
            r_count <= r_count + CNTW'(1);
          end else if (!w_push[gi] && w_pop[gi]) begin
            r_count <= r_count - CNTW'(1);
          end
        end
      end
    end
  endgenerate

  // Contention goes to the lane that did not win last; otherwise whichever has data.
  always_comb begin
    w_grant_valid = |w_nonempty;
    w_grant_lane  = 1'b0;
    if (&w_nonempty) begin
      w_grant_lane = ~r_last_grant;
    end else if (w_nonempty[1]) begin
      w_grant_lane = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_last_grant <= 1'b1;
      r_overflow   <= 2'b00;
    end else begin
      r_valid_out <= w_grant_valid;
      r_overflow  <= r_overflow | w_drop;
      if (w_grant_valid) begin
        r_data_out   <= w_head[w_grant_lane];
        r_last_grant <= w_grant_lane;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign full0     = w_full[0];
  assign full1     = w_full[1];
  assign overflow  = r_overflow;

endmodule
